tile_scheduler: RTL
===================

// Module: tile_scheduler
// PURPOSE
//  Frame-level sequencer for the tile rasterizer. Walks the screen in tileDim x tileDim tiles, left-to-right then
//  top-to-bottom. Drives rasterTileID/startRasterizing/offsets into the rasterizer and ping-pongs its two colour tile
//  buffers. Hands each finished buffer to the framebuffer writeback unit, so rasterizing tile N+1 overlaps writeback of tile N.
// PARAMETERS
//  tileDim       8'd4    tile edge in pixels; must match the rasterizer
//  screenWidth   640     pixels; multiple of tileDim, <=1024
//  screenHeight  480     pixels; multiple of tileDim, <=1024
// PORTS
//  BOARD_CLK         in   1   system clock
//  RESET_N           in   1   async active-low reset
//  frameStart        in   1   1-cycle pulse: begin a frame (ignored while busy)
//  busy              out  1   high from accepted frameStart until frameDone
//  frameDone         out  1   1-cycle pulse: last tile written back
//  startRasterizing  out  1   level request to rasterizer
//  rasterTileID      out  1   colour buffer the rasterizer fills
//  rasterxOffset     out  10  tile origin x for rasterizer
//  rasteryOffset     out  10  tile origin y for rasterizer
//  doneRasterizing   in   1   rasterizer done level
//  wbStart           out  1   1-cycle pulse: drain buffer wbTileID
//  wbTileID          out  1   buffer to write back
//  wbxOffset         out  10  framebuffer x of that tile
//  wbyOffset         out  10  framebuffer y of that tile
//  wbDone            in   1   1-cycle pulse: writeback finished
// BEHAVIOUR
//  Reset: all outputs 0; both FSMs idle; bufPending=2'b00; tile counters 0. Reset mid-frame aborts the frame with no frameDone.
//  Raster FSM: R_IDLE -> R_START -> R_WAIT -> R_RELEASE -> R_NEXT.
//  - R_IDLE: on frameStart, set busy. Clear tileX/tileY and curBuf=0. Go R_START.
//  - R_START: stall while bufPending[curBuf]. Otherwise register offsets and rasterTileID=curBuf, set startRasterizing=1,
//    go R_WAIT. Offsets and ID change only in this state.
//  - R_WAIT: hold startRasterizing=1 until doneRasterizing==1. Then drop start, set bufPending[curBuf], store tile
//    origin in bufX/bufY[curBuf], go R_RELEASE.
//  - R_RELEASE: wait for doneRasterizing==0, so the rasterizer has reached init. Go R_NEXT.
//  - R_NEXT: if the tile is last (x=screenWidth-tileDim, y=screenHeight-tileDim), go R_IDLE. Otherwise advance x by
//    tileDim; wrap to 0 and advance y at row end. Toggle curBuf, go R_START.
//  Writeback FSM: W_IDLE / W_BUSY.
//  - W_IDLE: if bufPending[wbNext], pulse wbStart with wbTileID=wbNext, wbx/yOffset=bufX/bufY[wbNext]. Go W_BUSY.
//    wbNext resets to 0 and alternates, so drain order equals raster order.
//  - W_BUSY: on wbDone, clear bufPending[wbTileID], toggle wbNext, go W_IDLE. Outputs hold until the next wbStart.
//  Simultaneous set (raster) and clear (wbDone) of bufPending always hit different buffers; both take effect.
//  A buffer freed by wbDone in cycle t may start rasterizing in cycle t+1.
//  frameDone: pulse 1 cycle when raster FSM is in R_IDLE with busy=1, bufPending==0, W_IDLE. busy clears in the same cycle.
//  frameStart while busy: ignored, no queueing. wbDone in W_IDLE: ignored.
//  Offset arithmetic is 10-bit unsigned; no wrap is possible given the parameter limits.
//  Latency: frameStart -> startRasterizing = 2 cycles; doneRasterizing -> wbStart = 2 cycles when the writeback unit is idle.
// CONFIGURATION
//  TILE_SCHED_PERF_EN defined: adds outputs frameCycles[31:0] and stallCycles[31:0].
//  - frameCycles counts cycles with busy=1.
//  - stallCycles counts cycles in R_START blocked by bufPending.
//  - Both clear on an accepted frameStart, hold after frameDone, and reset to 0.
//  TILE_SCHED_PERF_EN undefined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//  (Bench params: tileDim=4, screenWidth=8, screenHeight=8, giving 4 tiles.)
//  1 Reset: RESET_N low mid-R_WAIT -> all outputs 0 next edge; no frameDone; a later frameStart restarts at (0,0), ID 0.
//  2 Frame order: frameStart, rasterizer model done 5 cycles after start, wb model 3 cycles ->
//    raster offsets (0,0)(4,0)(0,4)(4,4), IDs 0,1,0,1; wb offsets same order; exactly one frameDone; busy then 0.
//  3 Back-pressure: wb model 40 cycles -> third raster (ID 0) holds in R_START until the cycle after tile-0 wbDone;
//    never two wbStart without an intervening wbDone.
//  4 Handshake: doneRasterizing held high 6 cycles after start drops -> no new startRasterizing until it falls.
//  5 Ignored inputs: frameStart pulsed mid-frame and wbDone pulsed in W_IDLE -> tile sequence and frameDone count unchanged.
//  6 TILE_SCHED_PERF_EN, setup of test 3 -> stallCycles > 0 and equals the R_START blocked cycles;
//    frameCycles equals the busy-high cycle count.

Source files
------------

// File: rtl/tile_scheduler.sv
// Frame sequencer: walks the screen in tiles, ping-pongs two colour buffers between the rasterizer
// and the writeback unit. Optional perf counters are enabled with `define TILE_SCHED_PERF_EN.
module tile_scheduler #(
  parameter int unsigned tileDim      = 4,
  parameter int unsigned screenWidth  = 640,
  parameter int unsigned screenHeight = 480
) (
  input  logic       BOARD_CLK,
  input  logic       RESET_N,
  input  logic       frameStart,
  output logic       busy,
  output logic       frameDone,
  output logic       startRasterizing,
  output logic       rasterTileID,
  output logic [9:0] rasterxOffset,
  output logic [9:0] rasteryOffset,
  input  logic       doneRasterizing,
  output logic       wbStart,
  output logic       wbTileID,
  output logic [9:0] wbxOffset,
  output logic [9:0] wbyOffset,
  input  logic       wbDone
`ifdef TILE_SCHED_PERF_EN
  ,
  output logic [31:0] frameCycles,
  output logic [31:0] stallCycles
`endif
);

  localparam logic [9:0] Step  = 10'(tileDim);
  localparam logic [9:0] LastX = 10'(screenWidth - tileDim);
  localparam logic [9:0] LastY = 10'(screenHeight - tileDim);

  typedef enum logic [2:0] {RIdle, RStart, RWait, RRelease, RNext} r_state_e;
  typedef enum logic {WIdle, WBusy} w_state_e;

  r_state_e        r_state_q, r_state_d;
  w_state_e        w_state_q, w_state_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic [9:0]      tile_x_q, tile_x_d;
  logic [9:0]      tile_y_q, tile_y_d;
  logic            cur_buf_q, cur_buf_d;
  logic            start_q, start_d;
  logic            raster_id_q, raster_id_d;
  logic [9:0]      rx_q, rx_d;
  logic [9:0]      ry_q, ry_d;
  logic [1:0]      buf_pending_q, buf_pending_d;
  logic [1:0][9:0] buf_x_q, buf_x_d;
  logic [1:0][9:0] buf_y_q, buf_y_d;
  logic            wb_next_q, wb_next_d;
  logic            wb_start_q, wb_start_d;
  logic            wb_id_q, wb_id_d;
  logic [9:0]      wbx_q, wbx_d;
  logic [9:0]      wby_q, wby_d;
  logic [1:0]      pend_set, pend_clr, pend_avail;

  always_comb begin
    r_state_d     = r_state_q;
    w_state_d     = w_state_q;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    tile_x_d      = tile_x_q;
    tile_y_d      = tile_y_q;
    cur_buf_d     = cur_buf_q;
    start_d       = start_q;
    raster_id_d   = raster_id_q;
    rx_d          = rx_q;
    ry_d          = ry_q;
    buf_x_d       = buf_x_q;
    buf_y_d       = buf_y_q;
    wb_next_d     = wb_next_q;
    wb_start_d    = 1'b0;
    wb_id_d       = wb_id_q;
    wbx_d         = wbx_q;
    wby_d         = wby_q;
    pend_set      = 2'b00;
    pend_clr      = 2'b00;

    if (w_state_q == WBusy && wbDone) begin
      pend_clr[wb_id_q] = 1'b1;
    end
    // Bypass the clear so a freed buffer can be reused on the very next cycle.
    pend_avail = buf_pending_q & ~pend_clr;

    unique case (r_state_q)
      RIdle: begin
        if (frameStart && !busy_q) begin
          busy_d    = 1'b1;
          tile_x_d  = '0;
          tile_y_d  = '0;
          cur_buf_d = 1'b0;
          r_state_d = RStart;
        end else if (busy_q && buf_pending_q == 2'b00 && w_state_q == WIdle) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
        end
      end
      RStart: begin
        if (!pend_avail[cur_buf_q]) begin
          rx_d        = tile_x_q;
          ry_d        = tile_y_q;
          raster_id_d = cur_buf_q;
          start_d     = 1'b1;
          r_state_d   = RWait;
        end
      end
      RWait: begin
        if (doneRasterizing) begin
          start_d             = 1'b0;
          pend_set[cur_buf_q] = 1'b1;
          buf_x_d[cur_buf_q]  = tile_x_q;
          buf_y_d[cur_buf_q]  = tile_y_q;
          r_state_d           = RRelease;
        end
      end
      RRelease: begin
        if (!doneRasterizing) begin
          r_state_d = RNext;
        end
      end
      RNext: begin
        if (tile_x_q == LastX && tile_y_q == LastY) begin
          r_state_d = RIdle;
        end else begin
          if (tile_x_q == LastX) begin
            tile_x_d = '0;
            tile_y_d = tile_y_q + Step;
          end else begin
            tile_x_d = tile_x_q + Step;
          end
          cur_buf_d = ~cur_buf_q;
          r_state_d = RStart;
        end
      end
      default: r_state_d = RIdle;
    endcase

    buf_pending_d = pend_avail | pend_set;

    unique case (w_state_q)
      WIdle: begin
        if (buf_pending_q[wb_next_q]) begin
          wb_start_d = 1'b1;
          wb_id_d    = wb_next_q;
          wbx_d      = buf_x_q[wb_next_q];
          wby_d      = buf_y_q[wb_next_q];
          w_state_d  = WBusy;
        end
      end
      WBusy: begin
        if (wbDone) begin
          wb_next_d = ~wb_next_q;
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state_q     <= RIdle;
      w_state_q     <= WIdle;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      tile_x_q      <= '0;
      tile_y_q      <= '0;
      cur_buf_q     <= 1'b0;
      start_q       <= 1'b0;
      raster_id_q   <= 1'b0;
      rx_q          <= '0;
      ry_q          <= '0;
      buf_pending_q <= 2'b00;
      buf_x_q       <= '0;
      buf_y_q       <= '0;
      wb_next_q     <= 1'b0;
      wb_start_q    <= 1'b0;
      wb_id_q       <= 1'b0;
      wbx_q         <= '0;
      wby_q         <= '0;
    end else begin
      r_state_q     <= r_state_d;
      w_state_q     <= w_state_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      tile_x_q      <= tile_x_d;
      tile_y_q      <= tile_y_d;
      cur_buf_q     <= cur_buf_d;
      start_q       <= start_d;
      raster_id_q   <= raster_id_d;
      rx_q          <= rx_d;
      ry_q          <= ry_d;
      buf_pending_q <= buf_pending_d;
      buf_x_q       <= buf_x_d;
      buf_y_q       <= buf_y_d;
      wb_next_q     <= wb_next_d;
      wb_start_q    <= wb_start_d;
      wb_id_q       <= wb_id_d;
      wbx_q         <= wbx_d;
      wby_q         <= wby_d;
    end
  end

  assign busy             = busy_q;
  assign frameDone        = frame_done_q;
  assign startRasterizing = start_q;
  assign rasterTileID     = raster_id_q;
  assign rasterxOffset    = rx_q;
  assign rasteryOffset    = ry_q;
  assign wbStart          = wb_start_q;
  assign wbTileID         = wb_id_q;
  assign wbxOffset        = wbx_q;
  assign wbyOffset        = wby_q;

`ifdef TILE_SCHED_PERF_EN
  logic [31:0] frame_cycles_q, frame_cycles_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    frame_cycles_d = frame_cycles_q;
    stall_cycles_d = stall_cycles_q;
    if (r_state_q == RIdle && frameStart && !busy_q) begin
      frame_cycles_d = '0;
      stall_cycles_d = '0;
    end else begin
      if (busy_q) begin
        frame_cycles_d = frame_cycles_q + 32'd1;
      end
      if (r_state_q == RStart && pend_avail[cur_buf_q]) begin
        stall_cycles_d = stall_cycles_q + 32'd1;
      end
    end
  end

  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_cycles_q <= '0;
      stall_cycles_q <= '0;
    end else begin
      frame_cycles_q <= frame_cycles_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign frameCycles = frame_cycles_q;
  assign stallCycles = stall_cycles_q;
`endif

endmodule
